lfsr_rng_arbiter: RTL and testbench

Controller that shares one LFSR pseudo-random generator (NUM_BITS wide, XNOR feedback, enable/seed-load interface) among NUM_REQ requesters. It loads seeds, advances the LFSR STEPS shifts per delivered word, and round-robin grants fresh words to requesters. It also flags sequence wrap-around, when the LFSR state returns to the loaded seed. It sits between the LFSR instance and the consumers, and is the only driver of the LFSR's E, Seed_DV and Seed_Data inputs.

---
 rtl/lfsr_rng_arbiter.sv | 146 ++++++++++++++
 tb/tb_lfsr_rng_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_arbiter.sv
// Shares one XNOR LFSR among NUM_REQ requesters: seeds it, steps it STEPS shifts
// per delivered word, grants words round-robin and flags return to the active seed.
`timescale 1ns/1ps
module lfsr_rng_arbiter #(
  parameter int NUM_BITS = 32,
  parameter int NUM_REQ  = 4,
  parameter int STEPS    = 32,
  parameter logic [NUM_BITS-1:0] DEFAULT_SEED = NUM_BITS'(1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                SEED_WR,
  input  logic [NUM_BITS-1:0] SEED_IN,
  output logic                SEED_ACK,
  output logic                SEED_ERR,
  input  logic [NUM_REQ-1:0]  REQ,
  output logic [NUM_REQ-1:0]  GNT,
  output logic [NUM_BITS-1:0] DATA,
  output logic                WRAP,
  input  logic                WRAP_CLR,
  output logic                LFSR_E,
  output logic                LFSR_SEED_DV,
  output logic [NUM_BITS-1:0] LFSR_SEED,
  input  logic [NUM_BITS-1:0] LFSR_DATA,
  input  logic                LFSR_DONE
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(STEPS + 1);
  localparam logic [IW:0]   NREQ     = (IW+1)'(NUM_REQ);
  localparam logic [IW-1:0] LAST     = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STEPS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {INIT, IDLE, SEED, STEP, DELIVER} state_t;

  state_t              state;
  logic [NUM_BITS-1:0] seed_q;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       idx;
  logic [CW-1:0]       cnt;
  logic                stepped;
  logic                wrap_q;
  logic                seed_bad;
  logic [IW-1:0]       sel;
  logic [IW:0]         pos;

  // all-ones is the XNOR lockup state and can never be a usable seed
  assign seed_bad = &SEED_IN;
  assign WRAP     = wrap_q;

  // walk offsets from high to low so the nearest requester at/above ptr wins
  always_comb begin
    sel = ptr;
    pos = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= NREQ) pos = pos - NREQ;
      if (REQ[pos[IW-1:0]]) sel = pos[IW-1:0];
    end
  end

  always_comb begin
    LFSR_E       = 1'b0;
    LFSR_SEED_DV = 1'b0;
    LFSR_SEED    = seed_q;
    SEED_ACK     = 1'b0;
    SEED_ERR     = 1'b0;
    GNT          = '0;
    DATA         = '0;
    if (!RST) begin
      case (state)
        INIT: begin
          LFSR_E       = 1'b1;
          LFSR_SEED_DV = 1'b1;
        end
        IDLE:    SEED_ERR = SEED_WR & seed_bad;
        SEED: begin
          LFSR_E       = 1'b1;
          LFSR_SEED_DV = 1'b1;
          SEED_ACK     = 1'b1;
        end
        STEP:    LFSR_E = 1'b1;
        DELIVER: begin
          GNT  = NUM_REQ'(1) << idx;
          DATA = LFSR_DATA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= INIT;
      seed_q  <= DEFAULT_SEED;
      ptr     <= '0;
      idx     <= '0;
      cnt     <= '0;
      stepped <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      // a fresh load restarts the wrap window; otherwise a new wrap beats a clear
      if (state == SEED)            wrap_q <= 1'b0;
      else if (LFSR_DONE && stepped) wrap_q <= 1'b1;
      else if (WRAP_CLR)             wrap_q <= 1'b0;

      case (state)
        INIT: begin
          stepped <= 1'b0;
          state   <= IDLE;
        end
        IDLE: begin
          if (SEED_WR) begin
            if (!seed_bad) begin
              seed_q <= SEED_IN;
              state  <= SEED;
            end
          end else if (|REQ) begin
            idx   <= sel;
            cnt   <= CNT_LOAD;
            state <= STEP;
          end
        end
        SEED: begin
          stepped <= 1'b0;
          state   <= IDLE;
        end
        STEP: begin
          cnt     <= cnt - 1'b1;
          stepped <= 1'b1;
          if (cnt == CNT_ONE) state <= DELIVER;
        end
        DELIVER: begin
          ptr   <= (idx == LAST) ? '0 : idx + 1'b1;
          state <= IDLE;
        end
        default: begin
          seed_q <= DEFAULT_SEED;
          state  <= INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Bench for lfsr_rng_arbiter: a default 32-bit instance and a 4-bit STEPS=1 instance,
// each wired to a behavioural XNOR LFSR, checked against vectors and a sequence model.
`timescale 1ns/1ps
module tb_lfsr_rng_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- default instance (32 bits, STEPS=32) ----------------
  logic        a_rst = 1'b1, a_seed_wr = 1'b0, a_wrap_clr = 1'b0;
  logic [31:0] a_seed_in = '0;
  logic [3:0]  a_req = '0, a_gnt;
  logic        a_ack, a_err, a_wrap, a_e, a_dv, a_done;
  logic [31:0] a_data, a_seed;
  logic [31:0] a_lfsr = '0;

  lfsr_rng_arbiter dut_a (
    .CLK(clk), .RST(a_rst), .SEED_WR(a_seed_wr), .SEED_IN(a_seed_in),
    .SEED_ACK(a_ack), .SEED_ERR(a_err), .REQ(a_req), .GNT(a_gnt), .DATA(a_data),
    .WRAP(a_wrap), .WRAP_CLR(a_wrap_clr), .LFSR_E(a_e), .LFSR_SEED_DV(a_dv),
    .LFSR_SEED(a_seed), .LFSR_DATA(a_lfsr), .LFSR_DONE(a_done));

  always @(posedge clk)
    if (a_e) a_lfsr <= a_dv ? a_seed : {a_lfsr[30:0], ~(a_lfsr[31] ^ a_lfsr[21] ^ a_lfsr[1] ^ a_lfsr[0])};
  assign a_done = (a_lfsr == a_seed);

  // ---------------- small instance (4 bits, STEPS=1) ----------------
  logic       b_rst = 1'b1, b_seed_wr = 1'b0, b_wrap_clr = 1'b0;
  logic [3:0] b_seed_in = '0;
  logic [3:0] b_req = '0, b_gnt;
  logic       b_ack, b_err, b_wrap, b_e, b_dv, b_done;
  logic [3:0] b_data, b_seed;
  logic [3:0] b_lfsr = '0;

  lfsr_rng_arbiter #(.NUM_BITS(4), .NUM_REQ(4), .STEPS(1), .DEFAULT_SEED(4'h1)) dut_b (
    .CLK(clk), .RST(b_rst), .SEED_WR(b_seed_wr), .SEED_IN(b_seed_in),
    .SEED_ACK(b_ack), .SEED_ERR(b_err), .REQ(b_req), .GNT(b_gnt), .DATA(b_data),
    .WRAP(b_wrap), .WRAP_CLR(b_wrap_clr), .LFSR_E(b_e), .LFSR_SEED_DV(b_dv),
    .LFSR_SEED(b_seed), .LFSR_DATA(b_lfsr), .LFSR_DONE(b_done));

  always @(posedge clk)
    if (b_e) b_lfsr <= b_dv ? b_seed : {b_lfsr[2:0], ~(b_lfsr[3] ^ b_lfsr[2])};
  assign b_done = (b_lfsr == b_seed);

  // ---------------- reference helpers ----------------
  function automatic logic [31:0] adv32(input logic [31:0] s, input int n);
    for (int i = 0; i < n; i++) s = {s[30:0], ~(s[31] ^ s[21] ^ s[1] ^ s[0])};
    return s;
  endfunction

  function automatic logic [3:0] adv4(input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) s = {s[2:0], ~(s[3] ^ s[2])};
    return s;
  endfunction

  function automatic int rr_pick(input int p, input logic [3:0] m);
    for (int k = 0; k < 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Start in an IDLE cycle, raise the mask, wait for the grant, drop REQ.
  task automatic txn(input bit sm, input logic [3:0] m, output logic [3:0] g,
                     output logic [31:0] d, output int lat);
    @(negedge clk);
    if (sm) b_req = m; else a_req = m;
    g = '0; d = '0; lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if ((sm ? b_gnt : a_gnt) != 4'b0) begin
        g   = sm ? b_gnt : a_gnt;
        d   = sm ? 32'(b_data) : a_data;
        lat = i;
        break;
      end
    end
    if (sm) b_req = '0; else a_req = '0;
  endtask

  task automatic seed_wr(input logic [3:0] v, output bit ack, output bit err, output bit e_seen);
    @(negedge clk);
    b_seed_wr = 1'b1; b_seed_in = v;
    ack = 1'b0; err = 1'b0; e_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      ack = b_ack; err = b_err; e_seen = b_e;
      if (ack || err) break;
      @(negedge clk);
    end
    b_seed_wr = 1'b0;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] data;
  } vec_t;
  vec_t tbl [10];
  logic [3:0] spec4 [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

  initial begin
    logic [3:0]  g;
    logic [31:0] d;
    int          lat, w, since, k, idx, m_ptr, m_shifts;
    bit          ack, err, e_seen, pend, expw, fin;
    logic [3:0]  m_seed, hold, v, m;

    tbl[0] = '{4'b0001, 4'b0001, 4'h1};
    tbl[1] = '{4'b0001, 4'b0001, 4'h3};
    tbl[2] = '{4'b1111, 4'b0010, 4'h7};
    tbl[3] = '{4'b1111, 4'b0100, 4'hE};
    tbl[4] = '{4'b1111, 4'b1000, 4'hD};
    tbl[5] = '{4'b1111, 4'b0001, 4'hB};
    tbl[6] = '{4'b1001, 4'b1000, 4'h6};
    tbl[7] = '{4'b0110, 4'b0010, 4'hC};
    tbl[8] = '{4'b0010, 4'b0010, 4'h9};
    tbl[9] = '{4'b1010, 4'b1000, 4'h2};
    spec4[0] = 4'h1; spec4[1] = 4'h3; spec4[2] = 4'h7; spec4[3] = 4'hE;

    // reset: outputs quiet, then INIT loads the default seed
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt_a", 32'(a_gnt), 32'h0);
    chk("rst_data_a", a_data, 32'h0);
    chk("rst_e_a", 32'(a_e), 32'h0);
    chk("rst_dv_a", 32'(a_dv), 32'h0);
    chk("rst_ack_err_a", 32'({a_ack, a_err}), 32'h0);
    chk("rst_wrap_a", 32'(a_wrap), 32'h0);
    chk("rst_e_b", 32'(b_e), 32'h0);
    a_rst = 1'b0; b_rst = 1'b0;
    #1;
    chk("init_e_dv_a", 32'({a_e, a_dv}), 32'h3);
    chk("init_seed_a", a_seed, 32'h1);
    chk("init_e_dv_b", 32'({b_e, b_dv}), 32'h3);

    // default instance: single grant at t+STEPS+1 carrying 32 shifts from seed 1
    txn(1'b0, 4'b0100, g, d, lat);
    chk("def_gnt", 32'(g), 32'h4);
    chk("def_lat", 32'(lat), 32'd33);
    chk("def_data", d, adv32(32'h1, 32));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("def_quiet_gnt", 32'(a_gnt), 32'h0);
      chk("def_quiet_data", a_data, 32'h0);
    end

    // reset mid-STEP with a grant pending (ptr=3 here)
    @(negedge clk);
    a_req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_gnt", 32'(a_gnt), 32'h0);
    end
    a_rst = 1'b1; a_req = '0;
    @(negedge clk);
    #1;
    chk("abort_rst_gnt", 32'(a_gnt), 32'h0);
    chk("abort_rst_e", 32'(a_e), 32'h0);
    a_rst = 1'b0;
    #1;
    chk("abort_init_e_dv", 32'({a_e, a_dv}), 32'h3);
    chk("abort_init_seed", a_seed, 32'h1);

    // REQ=1111 held: rotation from ptr 0, one word per STEPS+2 cycles
    @(negedge clk);
    a_req = 4'b1111;
    w = 0; since = 0;
    for (int c = 0; c < 250 && w < 5; c++) begin
      @(negedge clk);
      since++;
      if (a_gnt != 4'b0) begin
        chk("rr_gnt", 32'(a_gnt), 32'(1) << (w % 4));
        chk("rr_data", a_data, adv32(32'h1, 32 * (w + 1)));
        chk("rr_spacing", 32'(since), (w == 0) ? 32'd33 : 32'd34);
        since = 0;
        w++;
        if (w == 5) a_req = '0;
      end
    end
    chk("rr_count", 32'(w), 32'd5);

    // small instance: seed 0, then the vector table
    seed_wr(4'h0, ack, err, e_seen);
    chk("seed0_ack", 32'({ack, err}), 32'h2);
    @(negedge clk);
    chk("seed0_loaded", 32'(b_lfsr), 32'h0);
    for (int i = 0; i < 10; i++) begin
      txn(1'b1, tbl[i].req, g, d, lat);
      chk($sformatf("tbl%0d_gnt", i), 32'(g), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_data", i), d, 32'(tbl[i].data));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'd2);
    end

    // all-ones seed rejected without touching the LFSR; next valid seed accepted
    hold = b_lfsr;
    seed_wr(4'hF, ack, err, e_seen);
    chk("bad_seed_err_ack", 32'({ack, err}), 32'h1);
    chk("bad_seed_no_e", 32'(e_seen), 32'h0);
    chk("bad_seed_active", 32'(b_seed), 32'h0);
    @(negedge clk);
    chk("bad_seed_lfsr_hold", 32'(b_lfsr), 32'(hold));
    seed_wr(4'h0, ack, err, e_seen);
    chk("reseed_ack", 32'({ack, err}), 32'h2);

    // REQ held from seed 0: full 15-state period, WRAP set/clear interplay
    @(negedge clk);
    b_req = 4'b0001;
    w = 0; since = 0; pend = 0; expw = 0; fin = 0;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      since++;
      if (pend) begin
        chk($sformatf("wrap_after_w%0d", w), 32'(b_wrap), 32'(expw));
        pend = 0; b_wrap_clr = 1'b0;
        if (w == 31) fin = 1;
      end
      if (b_gnt != 4'b0) begin
        w++;
        chk("hold_gnt", 32'(b_gnt), 32'h1);
        chk("hold_data", 32'(b_data), 32'(adv4(4'h0, w)));
        if (w <= 4) chk("hold_spec_word", 32'(b_data), 32'(spec4[w-1]));
        chk("hold_spacing", 32'(since), (w == 1) ? 32'd2 : 32'd3);
        since = 0;
        if (w == 14 || w == 15 || w == 29 || w == 30) chk("wrap_pre", 32'(b_wrap), 32'h0);
        if (w == 15) begin pend = 1; expw = 1; end
        if (w == 16 || w == 30 || w == 31) begin
          b_wrap_clr = 1'b1; pend = 1; expw = (w == 30);
        end
        if (w == 31) b_req = '0;
      end
    end
    chk("hold_done", 32'(fin), 32'h1);

    // randomized grants and seed loads against the sequence model
    m_ptr = 1; m_seed = 4'h0; m_shifts = 31;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        v = 4'($urandom_range(0, 15));
        seed_wr(v, ack, err, e_seen);
        if (v == 4'hF) chk("rnd_seed_bad", 32'({ack, err}), 32'h1);
        else begin
          chk("rnd_seed_ok", 32'({ack, err}), 32'h2);
          m_seed = v; m_shifts = 0;
        end
      end else begin
        m = 4'($urandom_range(1, 15));
        idx = rr_pick(m_ptr, m);
        m_shifts++;
        txn(1'b1, m, g, d, lat);
        chk("rnd_gnt", 32'(g), 32'(1) << idx);
        chk("rnd_data", d, 32'(adv4(m_seed, m_shifts)));
        chk("rnd_lat", 32'(lat), 32'd2);
        m_ptr = (idx + 1) % 4;
      end
    end

    k = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
